// File: rtl/iter_multiplier.sv
// Iterative shift-add multiplier: RV64M MUL/MULH/MULHSU/MULHU plus MULW, BITS_PER_CYCLE bits per cycle.
// Define MULT_EARLY_EXIT_EN to leave CALC once the remaining multiplier bits are all zero.
module iter_multiplier #(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned BITS_PER_CYCLE = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mul_start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [1:0]      op,
    input  logic            word,
    input  logic            next,
    output logic [XLEN-1:0] mul_result,
    output logic            mul_ok,
    output logic            busy
);

    localparam int unsigned N_FULL = XLEN / BITS_PER_CYCLE;
    localparam int unsigned N_WORD = 32 / BITS_PER_CYCLE;
    localparam int unsigned CW     = $clog2(N_FULL + 1);

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULH  = 2'b01;
    localparam logic [1:0] OP_MULHU = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic                word_q, word_d;
    logic                neg_q, neg_d;
    logic [2*XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]     mplier_q, mplier_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                ok_q, ok_d;

    logic [XLEN-1:0]     a_ext, b_ext, a_mag, b_mag;
    logic                a_neg, b_neg;
    logic [2*XLEN-1:0]   partial, prod_fix;
    logic [XLEN-1:0]     rest, sel;

    // Operand conditioning: word mode sign-extends the low halves so one magnitude path serves both.
    always_comb begin
        a_ext = word ? {{(XLEN-32){a[31]}}, a[31:0]} : a;
        b_ext = word ? {{(XLEN-32){b[31]}}, b[31:0]} : b;
        a_neg = (word || (op != OP_MULHU)) && a_ext[XLEN-1];
        b_neg = (word || (op == OP_MUL) || (op == OP_MULH)) && b_ext[XLEN-1];
        a_mag = a_neg ? ('0 - a_ext) : a_ext;
        b_mag = b_neg ? ('0 - b_ext) : b_ext;
    end

    always_comb begin
        partial = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier_q[i]) begin
                partial = partial + (mcand_q << i);
            end
        end
        rest     = mplier_q >> BITS_PER_CYCLE;
        prod_fix = neg_q ? ('0 - acc_q) : acc_q;
        if (word_q) begin
            sel = {{(XLEN-32){prod_fix[31]}}, prod_fix[31:0]};
        end else if (op_q == OP_MUL) begin
            sel = prod_fix[XLEN-1:0];
        end else begin
            sel = prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        word_d   = word_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ok_d     = ok_q;
        if (next) begin
            state_d = S_IDLE;
            ok_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (mul_start) begin
                        op_d     = op;
                        word_d   = word;
                        neg_d    = a_neg ^ b_neg;
                        mcand_d  = {{XLEN{1'b0}}, a_mag};
                        mplier_d = b_mag;
                        acc_d    = '0;
                        cnt_d    = word ? CW'(N_WORD) : CW'(N_FULL);
                        state_d  = S_CALC;
                    end
                end
                S_CALC: begin
                    // Multiplicand shifts up as multiplier shifts down, keeping chunk alignment exact.
                    acc_d    = acc_q + partial;
                    mcand_d  = mcand_q << BITS_PER_CYCLE;
                    mplier_d = rest;
                    cnt_d    = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = S_FIX;
                    end
`ifdef MULT_EARLY_EXIT_EN
                    if (rest == '0) begin
                        state_d = S_FIX;
                    end
`else
`endif
                end
                S_FIX: begin
                    result_d = sel;
                    ok_d     = 1'b1;
                    state_d  = S_DONE;
                end
                S_DONE: begin
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ok_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            word_q   <= word_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ok_q     <= ok_d;
        end
    end

    assign mul_result = result_q;
    assign mul_ok     = ok_q;
    assign busy       = (state_q == S_CALC) || (state_q == S_FIX);

endmodule

// File: tb/tb_iter_multiplier.sv
// Scoreboard bench for iter_multiplier (XLEN=64, BITS_PER_CYCLE=2); honours MULT_EARLY_EXIT_EN for latency.
module tb_iter_multiplier;

    localparam int unsigned XLEN = 64;
    localparam int unsigned BPC  = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            mul_start;
    logic [XLEN-1:0] a, b;
    logic [1:0]      op;
    logic            word;
    logic            next;
    logic [XLEN-1:0] mul_result;
    logic            mul_ok;
    logic            busy;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    int          lat_q[$];

    iter_multiplier #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC)) dut (
        .clk(clk), .rst_n(rst_n), .mul_start(mul_start), .a(a), .b(b), .op(op),
        .word(word), .next(next), .mul_result(mul_result), .mul_ok(mul_ok), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_result(input logic [63:0] ai, input logic [63:0] bi,
                                                 input logic [1:0] opi, input logic wi);
        logic [127:0] ae, be, p;
        logic [63:0]  w;
        if (wi) begin
            w = {{32{ai[31]}}, ai[31:0]} * {{32{bi[31]}}, bi[31:0]};
            return {{32{w[31]}}, w[31:0]};
        end
        ae = (opi != 2'b11) ? {{64{ai[63]}}, ai} : {64'b0, ai};
        be = (opi == 2'b00 || opi == 2'b01) ? {{64{bi[63]}}, bi} : {64'b0, bi};
        p  = ae * be;
        return (opi == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    function automatic int model_lat(input logic [63:0] bi, input logic [1:0] opi, input logic wi);
        logic [63:0] bv, bm;
        logic        bs;
        int          chunks;
        bv = wi ? {{32{bi[31]}}, bi[31:0]} : bi;
        bs = wi || opi == 2'b00 || opi == 2'b01;
        bm = (bs && bv[63]) ? (64'd0 - bv) : bv;
        chunks = 1;
        while ((bm >> (chunks * BPC)) != 64'd0) chunks++;
`ifdef MULT_EARLY_EXIT_EN
        return chunks + 2;
`else
        return (wi ? 32 / BPC : 64 / BPC) + 2;
`endif
    endfunction

    // Drives one request through its accept edge, then scrambles the operands.
    task automatic start_op(input logic [63:0] ai, input logic [63:0] bi, input logic [1:0] opi, input logic wi);
        a = ai; b = bi; op = opi; word = wi; mul_start = 1'b1;
        exp_q.push_back(model_result(ai, bi, opi, wi));
        lat_q.push_back(model_lat(bi, opi, wi));
        @(posedge clk); #1;
        mul_start = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        op = 2'($urandom_range(0, 3)); word = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_ok(output int edges, output bit timeout);
        edges = 1;
        while (!mul_ok && edges < 300) begin
            @(posedge clk); #1;
            edges++;
        end
        timeout = !mul_ok;
    endtask

    task automatic pulse_next();
        next = 1'b1;
        @(posedge clk); #1;
        next = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mul_start = 1'b0; next = 1'b0; a = '0; b = '0; op = '0; word = 1'b0;
        #23;
        checks++; if (mul_ok !== 1'b0) begin errors++; $display("FAIL reset_ok: got %b expected 0", mul_ok); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (mul_result !== 64'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", mul_result); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int e; bit t; bit busy_bad; bit hold_bad; logic [63:0] ex; int el;
        start_op(-64'sd3, 64'd7, 2'b00, 1'b0);
        ex = exp_q.pop_front(); el = lat_q.pop_front();
        busy_bad = 1'b0; e = 1;
        while (!mul_ok && e < 300) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            @(posedge clk); #1;
            e++;
        end
        t = !mul_ok;
        checks++; if (t) begin errors++; $display("FAIL basic_timeout: got no mul_ok expected mul_ok"); end
        checks++; if (e != el) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", e, el); end
        checks++; if (mul_result !== ex) begin errors++; $display("FAIL basic_result: got %h expected %h", mul_result, ex); end
        checks++; if (busy_bad) begin errors++; $display("FAIL basic_busy_window: got low expected high"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %b expected 0", busy); end
        hold_bad = 1'b0;
        a = 64'd5; b = 64'd9; op = 2'b00; mul_start = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (mul_ok !== 1'b1 || mul_result !== ex || busy !== 1'b0) hold_bad = 1'b1;
        end
        mul_start = 1'b0;
        checks++; if (hold_bad) begin errors++; $display("FAIL done_hold: got changed expected %h held", ex); end
        pulse_next();
        checks++; if (mul_ok !== 1'b0) begin errors++; $display("FAIL next_clear_ok: got %b expected 0", mul_ok); end
        checks++; if (mul_result !== ex) begin errors++; $display("FAIL next_keep_result: got %h expected %h", mul_result, ex); end
    endtask

    task automatic test_corners();
        logic [63:0] av[9];
        logic [63:0] bv[9];
        logic [1:0]  ov[9];
        int e; bit t; logic [63:0] ex; int el;
        av = '{'1, '1, '1, '1, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 64'h8000_0000_0000_0000,
               64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
        bv = '{'1, '1, '1, '1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'h8000_0000_0000_0000,
               64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
        ov = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10};
        for (int i = 0; i < 9; i++) begin
            start_op(av[i], bv[i], ov[i], 1'b0);
            wait_ok(e, t);
            ex = exp_q.pop_front(); el = lat_q.pop_front();
            checks++; if (t || e != el) begin errors++; $display("FAIL corner%0d_latency: got %0d expected %0d", i, e, el); end
            checks++; if (mul_result !== ex) begin errors++; $display("FAIL corner%0d_result: got %h expected %h", i, mul_result, ex); end
            pulse_next();
        end
    endtask

    task automatic test_word();
        int e; bit t; logic [63:0] ex; int el;
        start_op(64'h1234_5678_7FFF_FFFF, 64'd2, 2'b01, 1'b1);
        wait_ok(e, t);
        ex = exp_q.pop_front(); el = lat_q.pop_front();
        checks++; if (t || e != el) begin errors++; $display("FAIL word0_latency: got %0d expected %0d", e, el); end
        checks++; if (mul_result !== ex) begin errors++; $display("FAIL word0_result: got %h expected %h", mul_result, ex); end
        pulse_next();
        start_op(64'h8000_0000_8000_0000, 64'h8000_0000_0000_0001, 2'b11, 1'b1);
        wait_ok(e, t);
        ex = exp_q.pop_front(); el = lat_q.pop_front();
        checks++; if (t || e != el) begin errors++; $display("FAIL word1_latency: got %0d expected %0d", e, el); end
        checks++; if (mul_result !== ex) begin errors++; $display("FAIL word1_result: got %h expected %h", mul_result, ex); end
        pulse_next();
    endtask

    task automatic test_abort();
        int e; bit t; logic [63:0] ex; int el;
        start_op(64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_1234_5678, 2'b10, 1'b0);
        void'(exp_q.pop_back()); void'(lat_q.pop_back());
        repeat (9) begin @(posedge clk); #1; end
        pulse_next();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (mul_ok !== 1'b0) begin errors++; $display("FAIL abort_ok: got %b expected 0", mul_ok); end
        mul_start = 1'b1; a = 64'd3; b = 64'd3;
        pulse_next();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_with_next: got busy %b expected 0", busy); end
        start_op(64'hFEDC_BA98_7654_3210, 64'hC000_0000_0000_0123, 2'b01, 1'b0);
        wait_ok(e, t);
        ex = exp_q.pop_front(); el = lat_q.pop_front();
        checks++; if (t || e != el) begin errors++; $display("FAIL after_abort_latency: got %0d expected %0d", e, el); end
        checks++; if (mul_result !== ex) begin errors++; $display("FAIL after_abort_result: got %h expected %h", mul_result, ex); end
        pulse_next();
    endtask

    task automatic test_async_reset();
        int e; bit t; logic [63:0] ex; int el;
        start_op(64'h7777_1111_2222_3333, 64'h9999_0000_0000_0001, 2'b00, 1'b0);
        void'(exp_q.pop_back()); void'(lat_q.pop_back());
        repeat (5) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mul_ok !== 1'b0) begin errors++; $display("FAIL areset_ok: got %b expected 0", mul_ok); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", busy); end
        checks++; if (mul_result !== 64'd0) begin errors++; $display("FAIL areset_result: got %h expected 0", mul_result); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        start_op(64'h8000_0000_0000_0000, 64'd4, 2'b11, 1'b0);
        wait_ok(e, t);
        ex = exp_q.pop_front(); el = lat_q.pop_front();
        checks++; if (t || e != el) begin errors++; $display("FAIL post_reset_latency: got %0d expected %0d", e, el); end
        checks++; if (mul_result !== ex) begin errors++; $display("FAIL post_reset_result: got %h expected %h", mul_result, ex); end
        pulse_next();
    endtask

    task automatic test_early_exit();
        logic [63:0] bv[3];
        int e; bit t; logic [63:0] ex; int el;
        bv = '{64'd0, 64'h10, 64'd3};
        for (int i = 0; i < 3; i++) begin
            start_op(64'h0000_0123_4567_89AB, bv[i], 2'b00, 1'b0);
            wait_ok(e, t);
            ex = exp_q.pop_front(); el = lat_q.pop_front();
            checks++; if (t || e != el) begin errors++; $display("FAIL early%0d_latency: got %0d expected %0d", i, e, el); end
            checks++; if (mul_result !== ex) begin errors++; $display("FAIL early%0d_result: got %h expected %h", i, mul_result, ex); end
            pulse_next();
        end
    endtask

    task automatic test_back_to_back();
        int e; bit t; logic [63:0] ex; int el;
        logic [63:0] ai, bi;
        for (int i = 0; i < 16; i++) begin
            ai = {$urandom, $urandom};
            bi = (i % 4 == 3) ? 64'(i) : {$urandom, $urandom};
            start_op(ai, bi, 2'(i % 4), 1'(i / 8));
            wait_ok(e, t);
            ex = exp_q.pop_front(); el = lat_q.pop_front();
            checks++; if (t || e != el) begin errors++; $display("FAIL b2b%0d_latency: got %0d expected %0d", i, e, el); end
            checks++; if (mul_result !== ex) begin errors++; $display("FAIL b2b%0d_result: got %h expected %h", i, mul_result, ex); end
            pulse_next();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_word();
        test_abort();
        test_async_reset();
        test_early_exit();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
